// File: rtl/pll_reset_pkg.sv
// rtl/pll_reset_pkg.sv - shared types and default timing constants for the PLL reset sequencer
package pll_reset_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_RETRIES         = 3;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - sequences PLL reset, waits for stable lock, then releases the core reset
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max_of3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                        LOCK_TIMEOUT_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, sys_rst_n_q, fault_q;
  logic             locked_s;
  logic             reenter;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    reenter = 1'b0;
    if (restart) begin
      state_d = ST_PLL_RST;
      retry_d = '0;
      reenter = 1'b1;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = ST_PLL_RST;
            end
          end
        end
        ST_STABLE: begin
          // Any dropout restarts the stability window with a fresh timeout.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_PLL_RST;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_PLL_RST;
      endcase
    end

    if (reenter || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAULT)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == ST_PLL_RST);
      sys_rst_n_q <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb/tb_pll_reset_ctrl.sv - self-checking bench for pll_reset_ctrl
module tb_pll_reset_ctrl;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTC = 32;
  localparam int MRT = 2;
  localparam int ATT = PRC + LTC;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;
  int e     = -1;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES      (PRC),
    .LOCK_STABLE_CYCLES  (LSC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .MAX_RETRIES         (MRT)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .locked        (locked),
    .restart       (restart),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #10 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
    e++;
  endtask

  task automatic goto_edge(input int t);
    while (e < t) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
    chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_retry"}, 32'(retry_cnt), 0);
    chk({tag, "_loss"}, 32'(lock_loss_cnt), 0);
  endtask

  task automatic release_reset();
    @(negedge refclk);
    rst_n = 1'b1;
    e = -1;
  endtask

  initial begin
    int k, d, r, p, f, n, nxt, waited, h, exp_loss;

    rst_n   = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    repeat (3) @(posedge refclk);
    @(negedge refclk);
    chk_reset_vals("reset");

    // Clean lock: locked sampled high at edge 10
    release_reset();
    k = 10;
    while (e < k + 14) begin
      nxt = e + 1;
      if (nxt >= k) locked = 1'b1;
      step();
      chk("clean_pll_rst", 32'(pll_rst), 32'(e < PRC - 1));
      chk("clean_sys_rst_n", 32'(sys_rst_n), 32'(e >= k + 2 + LSC));
      chk("clean_retry", 32'(retry_cnt), 0);
    end

    // Glitchy lock: 5 high, 1 low, then steady
    @(negedge refclk);
    rst_n  = 1'b0;
    locked = 1'b0;
    #2;
    chk_reset_vals("reset2");
    release_reset();
    k = 4 + int'($urandom_range(0, 8));
    while (e < k + 22) begin
      nxt = e + 1;
      locked = ((nxt >= k) && (nxt <= k + 4)) || (nxt >= k + 6);
      step();
      chk("glitch_sys_rst_n", 32'(sys_rst_n), 32'(e >= k + 6 + 2 + LSC));
    end

    // Lock loss in RUN, then relock
    d = e + 2 + int'($urandom_range(0, 4));
    r = d + 6 + int'($urandom_range(0, 5));
    while (e < r + 14) begin
      nxt = e + 1;
      locked = !((nxt >= d) && (nxt < r));
      step();
      chk("loss_sys_rst_n", 32'(sys_rst_n), 32'((e < d + 2) || (e >= r + 2 + LSC)));
      chk("loss_pll_rst", 32'(pll_rst), 32'((e >= d + 2) && (e < d + 2 + PRC)));
      chk("loss_cnt", 32'(lock_loss_cnt), 32'((e >= d + 2) ? 1 : 0));
    end

    // Timeouts into FAULT
    d = e + 1 + int'($urandom_range(0, 3));
    p = d + 2;
    while (e < p + (MRT + 1) * ATT + 6) begin
      nxt = e + 1;
      locked = (nxt < d);
      step();
      n = (e >= p) ? (e - p) / ATT : 0;
      if (n > MRT + 1) n = MRT + 1;
      chk("to_retry", 32'(retry_cnt), 32'((n > MRT) ? MRT : n));
      chk("to_fault", 32'(fault), 32'(n > MRT));
      chk("to_pll_rst", 32'(pll_rst), 32'((e >= p) && (n <= MRT) && (((e - p) % ATT) < PRC)));
      chk("to_sys_rst_n", 32'(sys_rst_n), 32'(e < p));
      chk("to_loss", 32'(lock_loss_cnt), 32'((e >= p) ? 2 : 1));
    end

    // Restart out of FAULT
    f = e + 1 + int'($urandom_range(0, 3));
    goto_edge(f - 1);
    chk("pre_restart_fault", 32'(fault), 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_fault", 32'(fault), 0);
    chk("rs_pll_rst", 32'(pll_rst), 1);
    chk("rs_retry", 32'(retry_cnt), 0);
    chk("rs_sys_rst_n", 32'(sys_rst_n), 0);
    chk("rs_loss", 32'(lock_loss_cnt), 2);

    // Async reset while in STABLE
    goto_edge(f + 5);
    locked = 1'b1;
    goto_edge(f + 10);
    chk("stable_pll_rst", 32'(pll_rst), 0);
    chk("stable_sys_rst_n", 32'(sys_rst_n), 0);
    #5;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");

    // Saturation of lock_loss_cnt
    release_reset();
    for (int i = 1; i <= 300; i++) begin
      waited = 0;
      while ((sys_rst_n !== 1'b1) && (waited < 100)) begin
        step();
        waited++;
      end
      chk("sat_run_wait", 32'(sys_rst_n), 1);
      h = int'($urandom_range(0, 3));
      repeat (h) step();
      locked = 1'b0;
      step();
      locked = 1'b1;
      step();
      step();
      exp_loss = (i > 255) ? 255 : i;
      chk("sat_sys_rst_n", 32'(sys_rst_n), 0);
      chk("sat_loss", 32'(lock_loss_cnt), 32'(exp_loss));
    end
    chk("sat_final", 32'(lock_loss_cnt), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer that sits beside the system PLL on the reference clock. It drives the PLL reset input and watches the PLL `locked` output. It releases the core system reset only after lock has been continuously stable, and it re-sequences automatically on loss of lock. A bounded number of lock attempts is made before a sticky fault is declared.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before an attempt is declared failed.
- `MAX_RETRIES`, 3: failed attempts tolerated. On the next failure the block enters FAULT.

Ports:
- `refclk`, in, 1: the single clock (50 MHz reference).
- `rst_n`, in, 1: asynchronous assert, active-low reset.
- `locked`, in, 1: PLL lock indicator, asynchronous to `refclk`.
- `restart`, in, 1: synchronous one-cycle request to re-run the full sequence.
- `pll_rst`, out, 1: PLL reset, active-high.
- `sys_rst_n`, out, 1: core reset, active-low, held low until lock is stable.
- `fault`, out, 1: sticky; set after retries are exhausted.
- `retry_cnt`, out, 2: failed attempts since the last RUN entry or restart.
- `lock_loss_cnt`, out, 8: saturating count of lock losses while in RUN.

## Operation
- `locked` passes through a 2-flop synchronizer, producing `locked_s`. No other logic samples raw `locked`.
- States and transitions:
  - **PLL_RST**: `pll_rst`=1 and `sys_rst_n`=0. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK. The cycle counter is cleared on every state entry.
  - **WAIT_LOCK**: `pll_rst`=0. If `locked_s`=1, go to STABLE.
    - If the counter reaches `LOCK_TIMEOUT_CYCLES` and `retry_cnt`==`MAX_RETRIES`, go to FAULT.
    - Otherwise on timeout, increment `retry_cnt` and go to PLL_RST.
  - **STABLE**: counts consecutive `locked_s`=1 cycles. If `locked_s`=0, return to WAIT_LOCK with a fresh timeout. Reaching `LOCK_STABLE_CYCLES` goes to RUN.
  - **RUN**: `sys_rst_n`=1 and `retry_cnt` is cleared on entry. If `locked_s`=0, increment `lock_loss_cnt` (saturating at 255) and go to PLL_RST.
  - **FAULT**: `pll_rst`=0, `sys_rst_n`=0, `fault`=1. Exits only on `rst_n` or `restart`.
- `restart` is accepted in any state. It goes to PLL_RST, clears `retry_cnt` and `fault`, and preserves `lock_loss_cnt`.
- Simultaneous events resolve in this order: `restart` beats lock loss, which beats timeout/stable completion.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.

## Timing
- Reset values: state=PLL_RST, `pll_rst`=1, `sys_rst_n`=0, `fault`=0, `retry_cnt`=0, `lock_loss_cnt`=0, and synchronizer flops=0.
- `rst_n` low forces all reset values immediately (asynchronously), including in mid-sequence.
- `pll_rst` is high for exactly `PLL_RST_CYCLES` edges after `rst_n` deassertion or after PLL_RST entry.
- `locked` sampled high at edge k gives `locked_s`=1 at edge k+1, STABLE entry at edge k+2, and `sys_rst_n` rising at edge k+2+`LOCK_STABLE_CYCLES`. A `locked` drop in RUN gives `sys_rst_n`=0 and `pll_rst`=1 at edge k+2.
- Counter width is $clog2 of the largest cycle parameter plus 1. Comparisons are equality against the parameter minus 1, so there is no wrap.

## Structure
- Package `pll_reset_pkg`: state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT) and the default parameter constants.
- Sub-module `sync_2ff` (1-bit, async active-low reset to 0) for the `locked` input.
- Everything else is one FSM plus one shared cycle counter in `pll_reset_ctrl`.

## Test plan
Bench parameters are `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `MAX_RETRIES`=2.
- **Clean lock:** release `rst_n`, raise `locked` at edge 10 → `pll_rst` high for edges 0–3, `sys_rst_n` rises at edge 20, `retry_cnt`=0.
- **Glitchy lock:** `locked` high for 5 cycles, low for 1, then steady → STABLE restarts and `sys_rst_n` rises 10 edges after the final rise.
- **Lock loss in RUN:** drop `locked` → `sys_rst_n`=0 and `pll_rst`=1 two edges later, `lock_loss_cnt`=1. Relock then releases again.
- **Timeout to fault:** hold `locked`=0 → three 32-cycle timeouts, `retry_cnt` counts 1 then 2, then `fault`=1 with `pll_rst`=0. A `restart` pulse clears `fault` and re-asserts `pll_rst` on the next edge.
- **Async reset mid-STABLE:** assert `rst_n`=0 → all outputs return to reset values without a clock edge.
- **Saturation:** 300 forced lock losses → `lock_loss_cnt` holds at 255.
